// File: rtl/vi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vi_mem_arbiter
//
// Shares the single core memory port among three requesters: I-cache line
// refill, D-cache line refill and store-buffer drain. One transaction is in
// flight at a time. Fixed priority WR > DC > IC, except that the I-cache is
// promoted to top priority once it has lost STARVE_MAX consecutive
// arbitrations while requesting.
//
// Ports
//   clk_i, rsn_i                    clock (rising edge), async active-low reset
//   ic_req_i / ic_addr_i            I-cache read request, held until ic_gnt_o
//   ic_gnt_o                        1-cycle pulse, I-cache request accepted
//   ic_data_ready_o / ic_data_o     1-cycle pulse with refill line (line holds)
//   dc_*                            same set for the D-cache
//   wr_req_i / wr_addr_i /
//   wr_data_i / wr_byte_i           store-buffer write, held until wr_gnt_o
//   wr_gnt_o                        1-cycle pulse, write issued this cycle
//   mem_read_o / mem_read_addr_o    memory read strobe (one cycle) and address
//   mem_data_ready_i / mem_data_i /
//   mem_addr_i                      memory response (level) tagged by address
//   mem_write_enable_o / mem_write_addr_o /
//   mem_write_data_o / mem_write_byte_o   memory write strobe and fields
//   timeout_o                       1-cycle pulse, outstanding read abandoned
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module vi_mem_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int LINE_W     = 128,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rsn_i,

    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_gnt_o,
    output logic              ic_data_ready_o,
    output logic [LINE_W-1:0] ic_data_o,

    input  logic              dc_req_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    output logic              dc_gnt_o,
    output logic              dc_data_ready_o,
    output logic [LINE_W-1:0] dc_data_o,

    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_byte_i,
    output logic              wr_gnt_o,

    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_read_addr_o,
    input  logic              mem_data_ready_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic              mem_write_enable_o,
    output logic [ADDR_W-1:0] mem_write_addr_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_write_byte_o,
    output logic              timeout_o
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP      = 2'd2;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_TOP   = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]        state_reg;
    logic [SW-1:0]     starve_reg;
    logic [SW-1:0]     starve_next;
    logic [TW-1:0]     tmo_cnt_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              owner_dc_reg;

    logic              ic_gnt_reg;
    logic              dc_gnt_reg;
    logic              wr_gnt_reg;
    logic              ic_rdy_reg;
    logic              dc_rdy_reg;
    logic [LINE_W-1:0] ic_data_reg;
    logic [LINE_W-1:0] dc_data_reg;
    logic              mem_read_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_waddr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_wbyte_reg;
    logic              timeout_reg;

    logic              wr_eligible;
    logic              ic_promoted;
    logic              grant_wr;
    logic              grant_dc;
    logic              grant_ic;
    logic              resp_hit;

    // The store buffer still shows the request it was just granted during the
    // wr_gnt_o cycle, so that request must not be granted a second time.
    assign wr_eligible = wr_req_i && !wr_gnt_reg;
    assign ic_promoted = (starve_reg == STARVE_TOP);

    always_comb begin
        grant_wr = 1'b0;
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (ic_promoted && ic_req_i) begin
                grant_ic = 1'b1;
            end else if (wr_eligible) begin
                grant_wr = 1'b1;
            end else if (dc_req_i) begin
                grant_dc = 1'b1;
            end else if (ic_req_i) begin
                grant_ic = 1'b1;
            end
        end
    end

    // Starvation tracking only moves on IDLE decisions where the I-cache asks.
    always_comb begin
        starve_next = starve_reg;
        if ((state_reg == ST_IDLE) && ic_req_i) begin
            if (grant_ic) begin
                starve_next = '0;
            end else if (starve_reg != STARVE_TOP) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    // A response is never taken in the strobe cycle itself: a level-high
    // ready left over from an earlier transfer could otherwise alias.
    assign resp_hit = (state_reg == ST_READ_WAIT) && mem_data_ready_i &&
                      (mem_addr_i == rd_addr_reg) && !mem_read_reg;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_reg     <= ST_IDLE;
            starve_reg    <= '0;
            tmo_cnt_reg   <= '0;
            rd_addr_reg   <= '0;
            owner_dc_reg  <= 1'b0;
            ic_gnt_reg    <= 1'b0;
            dc_gnt_reg    <= 1'b0;
            wr_gnt_reg    <= 1'b0;
            ic_rdy_reg    <= 1'b0;
            dc_rdy_reg    <= 1'b0;
            ic_data_reg   <= '0;
            dc_data_reg   <= '0;
            mem_read_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
            mem_wbyte_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            ic_gnt_reg   <= 1'b0;
            dc_gnt_reg   <= 1'b0;
            wr_gnt_reg   <= 1'b0;
            ic_rdy_reg   <= 1'b0;
            dc_rdy_reg   <= 1'b0;
            mem_read_reg <= 1'b0;
            mem_we_reg   <= 1'b0;
            timeout_reg  <= 1'b0;
            starve_reg   <= starve_next;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_wr) begin
                        mem_we_reg    <= 1'b1;
                        wr_gnt_reg    <= 1'b1;
                        mem_waddr_reg <= wr_addr_i;
                        mem_wdata_reg <= wr_data_i;
                        mem_wbyte_reg <= wr_byte_i;
                    end else if (grant_dc || grant_ic) begin
                        rd_addr_reg  <= grant_dc ? dc_addr_i : ic_addr_i;
                        owner_dc_reg <= grant_dc;
                        mem_read_reg <= 1'b1;
                        dc_gnt_reg   <= grant_dc;
                        ic_gnt_reg   <= grant_ic;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= ST_READ_WAIT;
                    end
                end

                ST_READ_WAIT: begin
                    if (resp_hit) begin
                        if (owner_dc_reg) begin
                            dc_data_reg <= mem_data_i;
                            dc_rdy_reg  <= 1'b1;
                        end else begin
                            ic_data_reg <= mem_data_i;
                            ic_rdy_reg  <= 1'b1;
                        end
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_RESP;
                    end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                        timeout_reg <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                ST_RESP: begin
                    // data_ready pulse is visible during this state.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ic_gnt_o           = ic_gnt_reg;
    assign ic_data_ready_o    = ic_rdy_reg;
    assign ic_data_o          = ic_data_reg;
    assign dc_gnt_o           = dc_gnt_reg;
    assign dc_data_ready_o    = dc_rdy_reg;
    assign dc_data_o          = dc_data_reg;
    assign wr_gnt_o           = wr_gnt_reg;
    assign mem_read_o         = mem_read_reg;
    assign mem_read_addr_o    = rd_addr_reg;
    assign mem_write_enable_o = mem_we_reg;
    assign mem_write_addr_o   = mem_waddr_reg;
    assign mem_write_data_o   = mem_wdata_reg;
    assign mem_write_byte_o   = mem_wbyte_reg;
    assign timeout_o          = timeout_reg;

endmodule

// File: tb/tb_vi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vi_mem_arbiter
//
// Directed bench for vi_mem_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. A small memory responder can answer reads one
// cycle after the strobe; otherwise memory inputs are driven by hand.
// ---------------------------------------------------------------------------
module tb_vi_mem_arbiter;

    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rsn = 1'b0;

    logic              ic_req = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic              ic_gnt;
    logic              ic_data_ready;
    logic [LINE_W-1:0] ic_data;

    logic              dc_req = 1'b0;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic              dc_gnt;
    logic              dc_data_ready;
    logic [LINE_W-1:0] dc_data;

    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_byte = 1'b0;
    logic              wr_gnt;

    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_addr;
    logic              mem_data_ready;
    logic [LINE_W-1:0] mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wbyte;
    logic              timeout;

    // Hand-driven and auto-responder memory inputs, selected by auto_mem.
    logic              auto_mem = 1'b0;
    logic              man_ready = 1'b0;
    logic [ADDR_W-1:0] man_addr = '0;
    logic [LINE_W-1:0] man_data = '0;
    logic              auto_ready = 1'b0;
    logic [ADDR_W-1:0] auto_addr = '0;
    logic [LINE_W-1:0] auto_data = '0;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] arm_addr = '0;

    assign mem_data_ready = auto_mem ? auto_ready : man_ready;
    assign mem_addr       = auto_mem ? auto_addr  : man_addr;
    assign mem_data       = auto_mem ? auto_data  : man_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_reads      = 0;
    int n_writes     = 0;
    bit record       = 1'b0;
    int grant_q[$];

    localparam logic [LINE_W-1:0] D1    = 128'h11112222_33334444_55556666_77778888;
    localparam logic [LINE_W-1:0] D2    = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    localparam logic [LINE_W-1:0] D3    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [LINE_W-1:0] STALE = 128'hDEAD0000_DEAD0000_DEAD0000_DEAD0000;
    localparam logic [LINE_W-1:0] GOOD  = 128'h600D600D_600D600D_600D600D_600D600D;
    localparam logic [LINE_W-1:0] D5    = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
    localparam logic [LINE_W-1:0] D6    = 128'h66666666_66666666_66666666_66666666;

    vi_mem_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DATA_W(DATA_W),
        .STARVE_MAX(4), .TIMEOUT(255)
    ) dut (
        .clk_i              (clk),
        .rsn_i              (rsn),
        .ic_req_i           (ic_req),
        .ic_addr_i          (ic_addr),
        .ic_gnt_o           (ic_gnt),
        .ic_data_ready_o    (ic_data_ready),
        .ic_data_o          (ic_data),
        .dc_req_i           (dc_req),
        .dc_addr_i          (dc_addr),
        .dc_gnt_o           (dc_gnt),
        .dc_data_ready_o    (dc_data_ready),
        .dc_data_o          (dc_data),
        .wr_req_i           (wr_req),
        .wr_addr_i          (wr_addr),
        .wr_data_i          (wr_data),
        .wr_byte_i          (wr_byte),
        .wr_gnt_o           (wr_gnt),
        .mem_read_o         (mem_read),
        .mem_read_addr_o    (mem_read_addr),
        .mem_data_ready_i   (mem_data_ready),
        .mem_data_i         (mem_data),
        .mem_addr_i         (mem_addr),
        .mem_write_enable_o (mem_we),
        .mem_write_addr_o   (mem_waddr),
        .mem_write_data_o   (mem_wdata),
        .mem_write_byte_o   (mem_wbyte),
        .timeout_o          (timeout)
    );

    always #5 clk = ~clk;

    // Strobe counters and grant recorder (1=WR, 2=DC, 3=IC).
    always @(negedge clk) begin
        if (mem_read) n_reads = n_reads + 1;
        if (mem_we)   n_writes = n_writes + 1;
        if (record) begin
            if (wr_gnt) grant_q.push_back(1);
            if (dc_gnt) grant_q.push_back(2);
            if (ic_gnt) grant_q.push_back(3);
        end
    end

    // Memory model: answers a strobed read for one cycle, one cycle later.
    always @(negedge clk) begin
        auto_ready = 1'b0;
        if (arm) begin
            auto_ready = 1'b1;
            auto_addr  = arm_addr;
            auto_data  = {4{12'h000, arm_addr}};
            arm        = 1'b0;
        end
        if (auto_mem && mem_read) begin
            arm      = 1'b1;
            arm_addr = mem_read_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] expv);
        tests_run = tests_run + 1;
        if (obs !== expv) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        int n;
        bit saw;
        int exp_g[7];

        // ---------------- reset state ----------------
        cyc(); cyc();
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_gnts", {ic_gnt, dc_gnt, wr_gnt}, 3'b000);
        check_eq("rst_rdy_tmo", {ic_data_ready, dc_data_ready, timeout}, 3'b000);
        rsn = 1'b1;
        cyc();

        // ---------------- 1: single IC read, latency ----------------
        ic_req = 1'b1; ic_addr = 20'h08000;
        cyc();
        check_eq("t1_ic_gnt", ic_gnt, 1'b1);
        check_eq("t1_mem_read", mem_read, 1'b1);
        check_eq("t1_read_addr", mem_read_addr, 20'h08000);
        ic_req = 1'b0;
        cyc();
        check_eq("t1_strobe_one_cycle", {mem_read, ic_gnt, ic_data_ready}, 3'b000);
        man_ready = 1'b1; man_addr = 20'h08000; man_data = D1;
        cyc();
        check_eq("t1_ic_data_ready", ic_data_ready, 1'b1);
        check_eq("t1_ic_data", ic_data, D1);
        check_eq("t1_dc_not_ready", dc_data_ready, 1'b0);
        man_ready = 1'b0;
        cyc();
        check_eq("t1_ready_pulse", ic_data_ready, 1'b0);
        check_eq("t1_data_hold", ic_data, D1);
        cyc();

        // ---------------- 2: WR, DC, IC together ----------------
        #1; rd0 = n_reads; wr0 = n_writes;
        wr_req = 1'b1; wr_addr = 20'h00100; wr_data = 32'h000000A5; wr_byte = 1'b1;
        dc_req = 1'b1; dc_addr = 20'h02040;
        ic_req = 1'b1; ic_addr = 20'h03000;
        cyc();
        check_eq("t2_wr_first", {wr_gnt, dc_gnt, ic_gnt, mem_we, mem_read}, 5'b10010);
        check_eq("t2_write_fields", {mem_waddr, mem_wdata, mem_wbyte},
                 {20'h00100, 32'h000000A5, 1'b1});
        wr_req = 1'b0;
        cyc();
        check_eq("t2_dc_second", {wr_gnt, dc_gnt, ic_gnt, mem_we, mem_read}, 5'b01001);
        check_eq("t2_dc_addr", mem_read_addr, 20'h02040);
        dc_req = 1'b0;
        cyc();
        man_ready = 1'b1; man_addr = 20'h02040; man_data = D2;
        cyc();
        check_eq("t2_dc_ready", {dc_data_ready, ic_data_ready}, 2'b10);
        check_eq("t2_dc_data", dc_data, D2);
        check_eq("t2_ic_data_hold", ic_data, D1);
        man_ready = 1'b0;
        cyc();
        check_eq("t2_no_gnt_in_resp", ic_gnt, 1'b0);
        cyc();
        check_eq("t2_ic_third", {wr_gnt, dc_gnt, ic_gnt, mem_read}, 4'b0011);
        check_eq("t2_ic_addr", mem_read_addr, 20'h03000);
        ic_req = 1'b0;
        cyc();
        man_ready = 1'b1; man_addr = 20'h03000; man_data = D3;
        cyc();
        check_eq("t2_ic_ready", ic_data_ready, 1'b1);
        check_eq("t2_ic_data", ic_data, D3);
        man_ready = 1'b0;
        cyc(); #1;
        check_eq("t2_read_strobes", 32'(n_reads - rd0), 32'd2);
        check_eq("t2_write_strobes", 32'(n_writes - wr0), 32'd1);
        cyc();

        // ---------------- 3: IC anti-starvation ----------------
        auto_mem = 1'b1; record = 1'b1;
        wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 32'h12345678; wr_byte = 1'b0;
        dc_req = 1'b1; dc_addr = 20'h02080;
        ic_req = 1'b1; ic_addr = 20'h03100;
        for (int i = 0; i < 200; i++) begin
            cyc(); #1;
            if (grant_q.size() >= 7) break;
        end
        wr_req = 1'b0; dc_req = 1'b0; ic_req = 1'b0;
        check_eq("t3_grant_count_ge7", 1'(grant_q.size() >= 7), 1'b1);
        exp_g = '{1, 2, 1, 2, 3, 1, 2};
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("t3_grant_%0d", i),
                     32'((i < grant_q.size()) ? grant_q[i] : 0), 32'(exp_g[i]));
        end
        repeat (6) cyc();
        record = 1'b0;
        #1; auto_mem = 1'b0;
        cyc();

        // ---------------- 4: stale response ignored ----------------
        man_ready = 1'b1; man_addr = 20'h01000; man_data = STALE;
        ic_req = 1'b1; ic_addr = 20'h02000;
        cyc();
        check_eq("t4_ic_gnt", ic_gnt, 1'b1);
        ic_req = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            cyc();
            saw = saw | ic_data_ready | dc_data_ready;
        end
        check_eq("t4_stale_ignored", saw, 1'b0);
        man_addr = 20'h02000; man_data = GOOD;
        cyc();
        check_eq("t4_ready", ic_data_ready, 1'b1);
        check_eq("t4_data", ic_data, GOOD);
        man_ready = 1'b0;
        cyc();

        // ---------------- 5: timeout ----------------
        dc_req = 1'b1; dc_addr = 20'h04000;
        cyc();
        check_eq("t5_dc_gnt", dc_gnt, 1'b1);
        dc_req = 1'b0;
        n = 0; saw = 1'b0;
        while (!timeout && n < 400) begin
            cyc();
            n = n + 1;
            saw = saw | ic_data_ready | dc_data_ready;
        end
        check_eq("t5_timeout_cycles", 32'(n), 32'd255);
        check_eq("t5_no_data_ready", saw, 1'b0);
        cyc();
        check_eq("t5_timeout_pulse", timeout, 1'b0);
        ic_req = 1'b1; ic_addr = 20'h05000;
        cyc();
        check_eq("t5_next_ic_gnt", ic_gnt, 1'b1);
        ic_req = 1'b0;
        // Matching ready already present during the strobe cycle.
        man_ready = 1'b1; man_addr = 20'h05000; man_data = D5;
        cyc();
        check_eq("t5_strobe_cycle_ignored", ic_data_ready, 1'b0);
        cyc();
        check_eq("t5_ic_ready", ic_data_ready, 1'b1);
        check_eq("t5_ic_data", ic_data, D5);
        man_ready = 1'b0;
        cyc();

        // ---------------- 6: reset mid-read ----------------
        dc_req = 1'b1; dc_addr = 20'h06000;
        cyc();
        check_eq("t6_dc_gnt", dc_gnt, 1'b1);
        dc_req = 1'b0;
        cyc();
        rsn = 1'b0;
        #1;
        check_eq("t6_rst_strobes", {mem_read, mem_we, dc_gnt, ic_gnt, wr_gnt}, 5'b00000);
        check_eq("t6_rst_dc_data", dc_data, 128'h0);
        check_eq("t6_rst_ic_data", ic_data, 128'h0);
        check_eq("t6_rst_addrs", {mem_read_addr, mem_waddr}, 40'h0);
        cyc();
        rsn = 1'b1;
        man_ready = 1'b1; man_addr = 20'h06000; man_data = D6;
        saw = 1'b0;
        repeat (3) begin
            cyc();
            saw = saw | dc_data_ready | ic_data_ready | mem_read;
        end
        check_eq("t6_late_resp_ignored", saw, 1'b0);
        check_eq("t6_dc_data_still0", dc_data, 128'h0);
        man_ready = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
